// File: rtl/gpio_cmd_sequencer.sv
// gpio_cmd_sequencer: decodes toggle-handshaked GPIO command words, assembles an
// M_LEN x M_LEN kernel, streams image pixels to N conv channels, fetches result
// words for read-back and sequences RUN/EOP.
module gpio_cmd_sequencer #(
    parameter int GPIO_D      = 32,
    parameter int BITS_IMAGEN = 8,
    parameter int BITS_DATA   = 13,
    parameter int N           = 2,
    parameter int M_LEN       = 3,
    parameter int NB_ADDRESS  = 10,
    localparam int CH_W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic                                 i_CLK,
    input  logic                                 i_reset,
    input  logic [GPIO_D-1:0]                    i_gpio_data,
    output logic [GPIO_D-1:0]                    o_gpio_data,
    output logic [M_LEN*M_LEN*BITS_IMAGEN-1:0]   o_kernel,
    output logic                                 o_kernel_valid,
    output logic [NB_ADDRESS-1:0]                o_img_len,
    output logic [BITS_IMAGEN-1:0]               o_pix,
    output logic                                 o_pix_valid,
    output logic [CH_W-1:0]                      o_pix_ch,
    output logic                                 o_load,
    output logic                                 o_run,
    input  logic                                 i_eop,
    output logic                                 o_rd_req,
    input  logic                                 i_rd_valid,
    input  logic [BITS_DATA-1:0]                 i_rd_data
);

    localparam int ROW_W = M_LEN * BITS_IMAGEN;
    localparam int K_W   = M_LEN * ROW_W;
    localparam int KR_W  = (M_LEN > 1) ? $clog2(M_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ILOAD  = 2'd1,
        S_RDWAIT = 2'd2,
        S_RUN    = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CMD_KROW  = 3'd0,
        CMD_SIZE  = 3'd1,
        CMD_PIXEL = 3'd2,
        CMD_DREQ  = 3'd3,
        CMD_RUN   = 3'd4,
        CMD_CLR   = 3'd7
    } cmd_e;

    // Handshake
    logic                   sync1_q, sync2_q;
    logic                   seen_q, seen_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   accept;

    // Control
    state_e                 state_q, state_d, cur_state;

    // Kernel assembly
    logic [KR_W-1:0]        krow_q, krow_d;
    logic [K_W-1:0]         kernel_q, kernel_d;
    logic                   kvalid_q, kvalid_d;

    // Image streaming
    logic [NB_ADDRESS-1:0]  img_len_q, img_len_d;
    logic [NB_ADDRESS-1:0]  col_q, col_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [BITS_IMAGEN-1:0] pix_q, pix_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [CH_W-1:0]        pix_ch_q, pix_ch_d;

    // Run / read-back
    logic                   run_q, run_d;
    logic                   rd_req_q, rd_req_d;
    logic [BITS_DATA-1:0]   rd_data_q, rd_data_d;

    // Command word fields; host holds them stable until the ack toggles
    cmd_e                   cmd;
    logic [23:0]            payload;
    logic                   unused_gpio_bits;

    assign cmd              = cmd_e'(i_gpio_data[31:29]);
    assign payload          = i_gpio_data[24:1];
    assign unused_gpio_bits = ^{i_gpio_data[27:25], i_gpio_data[0]};

    // All registers; async reset discards any partial kernel or image load.
    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            seen_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= S_IDLE;
            krow_q      <= '0;
            kernel_q    <= '0;
            kvalid_q    <= 1'b0;
            img_len_q   <= '0;
            col_q       <= '0;
            ch_q        <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_ch_q    <= '0;
            run_q       <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            sync1_q     <= i_gpio_data[28];
            sync2_q     <= sync1_q;
            seen_q      <= seen_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            state_q     <= state_d;
            krow_q      <= krow_d;
            kernel_q    <= kernel_d;
            kvalid_q    <= kvalid_d;
            img_len_q   <= img_len_d;
            col_q       <= col_d;
            ch_q        <= ch_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            pix_ch_q    <= pix_ch_d;
            run_q       <= run_d;
            rd_req_q    <= rd_req_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Next-state and command decode; EOP is resolved before a command accepted in the same cycle.
    always_comb begin
        cur_state   = state_q;
        seen_d      = seen_q;
        ack_d       = ack_q;
        err_d       = err_q;
        krow_d      = krow_q;
        kernel_d    = kernel_q;
        kvalid_d    = 1'b0;
        img_len_d   = img_len_q;
        col_d       = col_q;
        ch_d        = ch_q;
        pix_d       = pix_q;
        pix_valid_d = 1'b0;
        pix_ch_d    = pix_ch_q;
        run_d       = 1'b0;
        rd_req_d    = 1'b0;
        rd_data_d   = rd_data_q;

        if (state_q == S_RUN && i_eop) begin
            cur_state = S_IDLE;
        end
        state_d = cur_state;

        // A read in flight owns the ack; new toggles wait until it is issued
        accept = (sync2_q != seen_q) && (state_q != S_RDWAIT);

        if (state_q == S_RDWAIT && i_rd_valid) begin
            rd_data_d = i_rd_data;
            ack_d     = ~ack_q;
            state_d   = S_IDLE;
        end

        if (accept) begin
            seen_d = sync2_q;
            ack_d  = ~ack_q;
            case (cmd)
                CMD_KROW: begin
                    if (cur_state == S_IDLE) begin
                        for (int unsigned r = 0; r < M_LEN; r++) begin
                            if (krow_q == KR_W'(r)) begin
                                kernel_d[r*ROW_W +: ROW_W] = payload[ROW_W-1:0];
                            end
                        end
                        if (krow_q == KR_W'(M_LEN - 1)) begin
                            krow_d   = '0;
                            kvalid_d = 1'b1;
                        end else begin
                            krow_d = krow_q + KR_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_SIZE: begin
                    if (cur_state == S_IDLE && payload[NB_ADDRESS-1:0] != '0) begin
                        img_len_d = payload[NB_ADDRESS-1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_PIXEL: begin
                    if (cur_state == S_ILOAD || (cur_state == S_IDLE && img_len_q != '0)) begin
                        pix_d       = payload[BITS_IMAGEN-1:0];
                        pix_valid_d = 1'b1;
                        pix_ch_d    = ch_q;
                        state_d     = S_ILOAD;
                        if (col_q == img_len_q - NB_ADDRESS'(1)) begin
                            col_d = '0;
                            if (ch_q == CH_W'(N - 1)) begin
                                ch_d    = '0;
                                state_d = S_IDLE;
                            end else begin
                                ch_d = ch_q + CH_W'(1);
                            end
                        end else begin
                            col_d = col_q + NB_ADDRESS'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_DREQ: begin
                    if (cur_state == S_IDLE) begin
                        rd_req_d = 1'b1;
                        state_d  = S_RDWAIT;
                        ack_d    = ack_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_RUN: begin
                    if (cur_state == S_IDLE) begin
                        run_d   = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_CLR: begin
                    err_d = 1'b0;
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end
    end

    // GPIO read-back word: ack toggle, status (error dominates busy), result data.
    always_comb begin
        o_gpio_data     = '0;
        o_gpio_data[31] = ack_q;
        if (err_q) begin
            o_gpio_data[30:29] = 2'b10;
        end else if (state_q != S_IDLE) begin
            o_gpio_data[30:29] = 2'b01;
        end
        o_gpio_data[BITS_DATA-1:0] = rd_data_q;
    end

    assign o_kernel       = kernel_q;
    assign o_kernel_valid = kvalid_q;
    assign o_img_len      = img_len_q;
    assign o_pix          = pix_q;
    assign o_pix_valid    = pix_valid_q;
    assign o_pix_ch       = pix_ch_q;
    assign o_load         = (state_q == S_ILOAD);
    assign o_run          = run_q;
    assign o_rd_req       = rd_req_q;

endmodule

// File: tb/tb_gpio_cmd_sequencer.sv
// tb_gpio_cmd_sequencer: directed plus randomized command traffic against a
// transaction-level model of the GPIO command sequencer.
module tb_gpio_cmd_sequencer;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_gpio_data;
    logic [31:0] o_gpio_data;
    logic [71:0] o_kernel;
    logic        o_kernel_valid;
    logic [9:0]  o_img_len;
    logic [7:0]  o_pix;
    logic        o_pix_valid;
    logic [0:0]  o_pix_ch;
    logic        o_load;
    logic        o_run;
    logic        i_eop;
    logic        o_rd_req;
    logic        i_rd_valid;
    logic [12:0] i_rd_data;

    gpio_cmd_sequencer #(
        .GPIO_D(32), .BITS_IMAGEN(8), .BITS_DATA(13), .N(N), .M_LEN(3), .NB_ADDRESS(10)
    ) dut (
        .i_CLK(clk), .i_reset(rst_n), .i_gpio_data(i_gpio_data), .o_gpio_data(o_gpio_data),
        .o_kernel(o_kernel), .o_kernel_valid(o_kernel_valid), .o_img_len(o_img_len),
        .o_pix(o_pix), .o_pix_valid(o_pix_valid), .o_pix_ch(o_pix_ch), .o_load(o_load),
        .o_run(o_run), .i_eop(i_eop), .o_rd_req(o_rd_req), .i_rd_valid(i_rd_valid),
        .i_rd_data(i_rd_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observed events
    logic [8:0] got_q[$];
    int   run_cnt = 0, rdreq_cnt = 0, kv_cnt = 0, ack_cnt = 0;
    logic prev_ack = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ack = 1'b0;
        end else begin
            if (o_pix_valid)    got_q.push_back({o_pix, o_pix_ch});
            if (o_run)          run_cnt++;
            if (o_rd_req)       rdreq_cnt++;
            if (o_kernel_valid) kv_cnt++;
            if (o_gpio_data[31] !== prev_ack) ack_cnt++;
            prev_ack = o_gpio_data[31];
        end
    end

    // Reference model (transaction level)
    bit          m_load, m_wait, m_run, m_err;
    int          m_len, m_k, m_kidx;
    logic [23:0] m_rows[3];
    int          e_run = 0, e_rdreq = 0, e_kv = 0, e_ack_cnt = 0;
    logic        e_ack = 1'b0;
    logic [12:0] e_rd = '0;
    logic [8:0]  exp_q[$];
    logic        vbit = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_load = 0; m_wait = 0; m_run = 0; m_err = 0;
        m_len = 0; m_k = 0; m_kidx = 0;
        for (int i = 0; i < 3; i++) m_rows[i] = '0;
        e_ack = 1'b0; e_rd = '0;
    endtask

    task automatic model_cmd(input logic [2:0] c, input logic [23:0] p, output bit acks);
        bit idle;
        idle = !m_load && !m_wait && !m_run;
        acks = 1;
        case (c)
            3'd0: if (idle) begin
                      m_rows[m_kidx] = p;
                      m_kidx = (m_kidx + 1) % 3;
                      if (m_kidx == 0) e_kv++;
                  end else m_err = 1;
            3'd1: if (idle && p[9:0] != 0) m_len = int'(p[9:0]); else m_err = 1;
            3'd2: if (m_load || (idle && m_len != 0)) begin
                      exp_q.push_back({p[7:0], 1'(m_k / m_len)});
                      m_k++;
                      if (m_k == N * m_len) begin m_k = 0; m_load = 0; end
                      else m_load = 1;
                  end else m_err = 1;
            3'd3: if (idle) begin m_wait = 1; e_rdreq++; acks = 0; end else m_err = 1;
            3'd4: if (idle) begin m_run = 1; e_run++; end else m_err = 1;
            3'd7: m_err = 0;
            default: m_err = 1;
        endcase
    endtask

    task automatic check_all(input string w);
        int st;
        st = m_err ? 2 : ((m_load || m_wait || m_run) ? 1 : 0);
        check({w, ":status"}, o_gpio_data[30:29], st);
        check({w, ":ackbit"}, o_gpio_data[31], e_ack);
        check({w, ":ackcnt"}, ack_cnt, e_ack_cnt);
        check({w, ":zero"}, o_gpio_data[28:13], 0);
        check({w, ":rddata"}, o_gpio_data[12:0], e_rd);
        check({w, ":imglen"}, o_img_len, m_len);
        check({w, ":load"}, o_load, m_load);
        check({w, ":runcnt"}, run_cnt, e_run);
        check({w, ":rdreqcnt"}, rdreq_cnt, e_rdreq);
        check({w, ":kvcnt"}, kv_cnt, e_kv);
        check({w, ":kernel"}, o_kernel, {m_rows[2], m_rows[1], m_rows[0]});
        check({w, ":pixcnt"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({w, ":pix"}, got_q.pop_front(), exp_q.pop_front());
    endtask

    task automatic issue(input logic [2:0] c, input logic [23:0] p);
        vbit = ~vbit;
        i_gpio_data = {c, vbit, 3'b000, p, 1'b0};
    endtask

    task automatic wait_ack(input string tag);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (o_gpio_data[31] === e_ack) seen = 1;
        end
        check({tag, ":ack_seen"}, seen, 1);
        @(negedge clk); #1;
    endtask

    task automatic wait_rdreq(input string tag);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk); #1;
            if (rdreq_cnt == e_rdreq) seen = 1;
        end
        check({tag, ":rdreq_seen"}, seen, 1);
    endtask

    task automatic rd_return(input int dly, input logic [12:0] val);
        repeat (dly) @(negedge clk);
        #1 i_rd_valid = 1'b1; i_rd_data = val;
        @(negedge clk); #1 i_rd_valid = 1'b0;
        m_wait = 0; e_rd = val;
    endtask

    task automatic cmd(input logic [2:0] c, input logic [23:0] p, input int rd_dly,
                       input logic [12:0] rd_val, input string tag);
        bit a;
        issue(c, p);
        model_cmd(c, p, a);
        if (!a) begin
            wait_rdreq(tag);
            rd_return(rd_dly, rd_val);
        end
        e_ack = ~e_ack; e_ack_cnt++;
        wait_ack(tag);
        check_all(tag);
    endtask

    task automatic pulse_eop();
        #1 i_eop = 1'b1;
        @(negedge clk); #1 i_eop = 1'b0;
        m_run = 0;
        @(negedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit a;
        rst_n = 1'b0; i_gpio_data = '0; i_eop = 1'b0; i_rd_valid = 1'b0; i_rd_data = '0;
        model_reset();
        repeat (3) @(negedge clk); #1;
        check("rst:gpio", o_gpio_data, 0);
        check("rst:kernel", o_kernel, 0);
        check("rst:misc", {o_kernel_valid, o_img_len, o_pix, o_pix_valid, o_pix_ch, o_load, o_run, o_rd_req}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk); #1;
        check_all("post_reset");

        // Pixel with no image length, then illegal opcodes
        cmd(3'd2, 24'h55, 0, 0, "pix_nolen");
        cmd(3'd7, 0, 0, 0, "clr1");
        cmd(3'd5, 24'h1, 0, 0, "cmd5");
        cmd(3'd7, 0, 0, 0, "clr2");
        cmd(3'd6, 24'h2, 0, 0, "cmd6");
        cmd(3'd7, 0, 0, 0, "clr3");

        // Directed kernel
        cmd(3'd0, 24'h010203, 0, 0, "krow0");
        cmd(3'd0, 24'h040506, 0, 0, "krow1");
        cmd(3'd0, 24'h070809, 0, 0, "krow2");
        check("kernel_const", o_kernel, 72'h070809_040506_010203);

        // Directed image: length 4, pixels 1..8
        cmd(3'd1, 24'd4, 0, 0, "size4");
        for (int i = 1; i <= 8; i++) cmd(3'd2, 24'(i), 0, 0, "pix_dir");

        // Directed read-back
        cmd(3'd3, 24'h0, 3, 13'h1ABC, "dreq_dir");
        check("rd_const", o_gpio_data[12:0], 13'h1ABC);

        // RUN / EOP and error while busy
        cmd(3'd4, 0, 0, 0, "run1");
        repeat (5) @(negedge clk); #1;
        check_all("run1_hold");
        pulse_eop();
        check_all("run1_eop");
        cmd(3'd4, 0, 0, 0, "run2");
        cmd(3'd4, 0, 0, 0, "run2_busy");
        pulse_eop();
        check_all("run2_eop");
        cmd(3'd7, 0, 0, 0, "clr4");

        // Extra toggles while a read holds the ack cancel out
        issue(3'd3, 0); model_cmd(3'd3, 0, a);
        wait_rdreq("dbl");
        issue(3'd4, 0); @(negedge clk); #1; issue(3'd4, 0);
        rd_return(3, 13'h0555);
        e_ack = ~e_ack; e_ack_cnt++;
        wait_ack("dbl");
        check_all("dbl");
        repeat (6) @(negedge clk); #1;
        check_all("dbl_late");

        // Zero length rejected; stray eop / rd_valid ignored
        cmd(3'd1, 24'd0, 0, 0, "size0");
        cmd(3'd7, 0, 0, 0, "clr5");
        pulse_eop();
        check_all("stray_eop");
        #1 i_rd_valid = 1'b1; i_rd_data = 13'h0F0F;
        @(negedge clk); #1 i_rd_valid = 1'b0;
        repeat (2) @(negedge clk); #1;
        check_all("stray_rdv");

        // Command accepted in the same cycle as EOP sees IDLE
        cmd(3'd4, 0, 0, 0, "run3");
        repeat (3) @(negedge clk); #1;
        issue(3'd0, 24'hA1B2C3);
        @(negedge clk); @(negedge clk); #1 i_eop = 1'b1;
        @(negedge clk); #1 i_eop = 1'b0;
        m_run = 0; model_cmd(3'd0, 24'hA1B2C3, a);
        e_ack = ~e_ack; e_ack_cnt++;
        wait_ack("eop_same");
        check_all("eop_same");

        // Randomized kernels, images, reads
        for (int i = 0; i < 5; i++) cmd(3'd0, 24'($urandom), 0, 0, "krow_rnd");
        for (int im = 0; im < 3; im++) begin
            int len;
            len = $urandom_range(1, 5);
            cmd(3'd1, 24'(len), 0, 0, "size_rnd");
            for (int i = 0; i < N * len; i++) cmd(3'd2, 24'($urandom), 0, 0, "pix_rnd");
        end
        for (int i = 0; i < 3; i++) cmd(3'd3, 0, $urandom_range(0, 6), 13'($urandom), "dreq_rnd");

        // Random command soup
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  c;
            logic [23:0] p;
            if (m_run && $urandom_range(0, 1) == 1) pulse_eop();
            c = 3'($urandom_range(0, 7));
            p = 24'($urandom);
            if (c == 3'd1) p = 24'($urandom_range(0, 4));
            cmd(c, p, $urandom_range(0, 5), 13'($urandom), "rnd");
        end

        // Reset in the middle of an image load
        if (m_run) pulse_eop();
        cmd(3'd7, 0, 0, 0, "pre_rst_clr");
        for (int i = 0; i < 20 && m_load; i++) cmd(3'd2, 24'($urandom), 0, 0, "drain");
        cmd(3'd1, 24'd4, 0, 0, "size_rst");
        for (int i = 0; i < 3; i++) cmd(3'd2, 24'($urandom), 0, 0, "pix_rst");
        check("mid_load", o_load, 1);
        rst_n = 1'b0; i_gpio_data = '0; vbit = 1'b0;
        repeat (2) @(negedge clk); #1;
        check("rst2:gpio", o_gpio_data, 0);
        check("rst2:kernel", o_kernel, 0);
        check("rst2:misc", {o_kernel_valid, o_img_len, o_pix, o_pix_valid, o_pix_ch, o_load, o_run, o_rd_req}, 0);
        model_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk); #1;
        check_all("post_rst2");
        cmd(3'd2, 24'h77, 0, 0, "pix_after_rst");
        cmd(3'd7, 0, 0, 0, "clr_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
